// File: rtl/data_mem.sv
// Word-organised data memory responding on the core's data-memory port.
// Reads complete after READ_LATENCY cycles through a mem_ready handshake.
// Writes always complete in the cycle they are presented.
// Misaligned, out-of-range and read+write requests complete at once with mem_error set.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   memread        read request (level)
//   memwrite       write request (level)
//   mem_addr       byte address
//   mem_writedata  write data
//   mem_readdata   read data, valid when mem_ready=1 for a read
//   mem_ready      current request completes this cycle
//   mem_error      current completing request was rejected
module data_mem #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter              INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_writedata,
  output logic [31:0] mem_readdata,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int unsigned AW = $clog2(DEPTH);
  // The request cycle is the first stall cycle, so WAIT covers the remaining
  // READ_LATENCY-1 cycles; the counter holds (WAIT cycles left - 1).
  localparam int unsigned LOAD = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [31:0]   mem [DEPTH];
  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    cnt_q;
  logic [31:0]   rdata_q;

  logic [AW-1:0] index;
  logic          misaligned;
  logic          out_of_range;
  logic          conflict;
  logic          bad;
  logic          req;
  logic          idle;
  logic          wr_en;
  logic          rd_go;

  assign index        = mem_addr[AW+1:2];
  assign misaligned   = |mem_addr[1:0];
  assign out_of_range = |mem_addr[31:AW+2];
  assign conflict     = memread & memwrite;
  assign bad          = misaligned | out_of_range | conflict;
  assign req          = memread | memwrite;
  assign idle         = (state_q == StIdle);
  assign wr_en        = idle & memwrite & ~memread & ~bad & ~reset;
  assign rd_go        = idle & memread & ~bad & (READ_LATENCY != 0);

  // Contents start at zero; reset never clears them.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[index] <= mem_writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_go) begin
            if (READ_LATENCY == 1) begin
              rdata_q <= mem[index];
              state_q <= StResp;
            end else begin
              idx_q   <= index;
              cnt_q   <= 2'(LOAD);
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == 2'd0) begin
            // Sampled at the capture edge, so earlier completed writes are seen.
            rdata_q <= mem[idx_q];
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_ready    = 1'b1;
    mem_error    = 1'b0;
    mem_readdata = rdata_q;
    if (READ_LATENCY == 0) begin
      mem_error    = req & bad;
      mem_readdata = (memread & ~bad) ? mem[index] : '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && bad) begin
            mem_error    = 1'b1;
            mem_readdata = '0;
          end else if (memread) begin
            mem_ready = 1'b0;
          end
        end
        StWait:  mem_ready = 1'b0;
        StResp:  mem_ready = 1'b1;
        default: mem_ready = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread       [4];
  logic        memwrite      [4];
  logic [31:0] mem_addr      [4];
  logic [31:0] mem_writedata [4];
  logic [31:0] mem_readdata  [4];
  logic        mem_ready     [4];
  logic        mem_error     [4];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk_data;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // One instance per read latency 0..3, each with its own request port.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem #(
      .DEPTH(1024),
      .READ_LATENCY(g),
      .INIT_FILE("")
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .memread(memread[g]),
      .memwrite(memwrite[g]),
      .mem_addr(mem_addr[g]),
      .mem_writedata(mem_writedata[g]),
      .mem_readdata(mem_readdata[g]),
      .mem_ready(mem_ready[g]),
      .mem_error(mem_error[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request on instance d, hold it until mem_ready, then score it.
  task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_stall,
                        input logic [31:0] exp_data, input bit exp_err, input bit chk_data);
    exp_t e;
    int   stalls;
    bit   done;
    e.data = exp_data;
    e.err = exp_err;
    e.chk_data = chk_data;
    sb_q.push_back(e);
    memread[d] = rd;
    memwrite[d] = wr;
    mem_addr[d] = addr;
    mem_writedata[d] = wdata;
    stalls = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (mem_ready[d]) begin
        done = 1;
      end else begin
        check_val($sformatf("d%0d err_in_wait", d), 32'(mem_error[d]), 32'd0);
        stalls++;
        if (stalls > 16) done = 1;
      end
    end
    check_val($sformatf("d%0d stall %h", d, addr), 32'(stalls), 32'(exp_stall));
    e = sb_q.pop_front();
    check_val($sformatf("d%0d error %h", d, addr), 32'(mem_error[d]), 32'(e.err));
    if (e.chk_data) check_val($sformatf("d%0d rdata %h", d, addr), mem_readdata[d], e.data);
    @(posedge clk);
    #1;
    memread[d] = 1'b0;
    memwrite[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      memread[i] = 1'b0;
      memwrite[i] = 1'b0;
      mem_addr[i] = '0;
      mem_writedata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("d%0d rst ready", i), 32'(mem_ready[i]), 32'd1);
      check_val($sformatf("d%0d rst error", i), 32'(mem_error[i]), 32'd0);
      check_val($sformatf("d%0d rst rdata", i), mem_readdata[i], 32'd0);
    end
    @(posedge clk);
    #1;

    // Latency 1: write then read, bad requests, conflict.
    access(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 0);
    access(1, 1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 1);
    access(1, 1, 0, 32'h13, 32'h0, 0, 32'h0, 1, 1);
    access(1, 0, 1, 32'h0001_0000, 32'h0BAD0BAD, 0, 32'h0, 1, 1);
    access(1, 1, 0, 32'h8000_0010, 32'h0, 0, 32'h0, 1, 1);
    access(1, 1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 1);
    access(1, 0, 1, 32'h20, 32'h11112222, 0, 32'h0, 0, 0);
    access(1, 1, 1, 32'h20, 32'hAAAA5555, 0, 32'h0, 1, 1);
    access(1, 1, 0, 32'h20, 32'h0, 1, 32'h11112222, 0, 1);
    access(1, 1, 0, 32'h0, 32'h0, 1, 32'h0, 0, 1);

    // Latency 3: three stall cycles, one response cycle, then idle.
    access(3, 0, 1, 32'h04, 32'h12345678, 0, 32'h0, 0, 0);
    access(3, 1, 0, 32'h04, 32'h0, 3, 32'h12345678, 0, 1);
    @(negedge clk);
    check_val("d3 idle ready", 32'(mem_ready[3]), 32'd1);
    check_val("d3 idle error", 32'(mem_error[3]), 32'd0);
    @(posedge clk);
    #1;

    // Latency 2: reset while waiting drops the read.
    access(2, 0, 1, 32'h10, 32'hCAFEF00D, 0, 32'h0, 0, 0);
    memread[2] = 1'b1;
    mem_addr[2] = 32'h10;
    @(negedge clk);
    check_val("d2 req ready", 32'(mem_ready[2]), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("d2 wait ready", 32'(mem_ready[2]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    memread[2] = 1'b0;
    @(negedge clk);
    check_val("d2 post-rst ready", 32'(mem_ready[2]), 32'd1);
    check_val("d2 post-rst rdata", mem_readdata[2], 32'd0);
    check_val("d2 post-rst error", 32'(mem_error[2]), 32'd0);
    @(posedge clk);
    #1;
    access(2, 1, 0, 32'h10, 32'h0, 2, 32'hCAFEF00D, 0, 1);
    access(1, 1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 1);

    // Latency 0: back-to-back write then combinational read.
    access(0, 0, 1, 32'h08, 32'h00000001, 0, 32'h0, 0, 0);
    access(0, 1, 0, 32'h08, 32'h0, 0, 32'h00000001, 0, 1);
    access(0, 1, 0, 32'h0A, 32'h0, 0, 32'h0, 1, 1);
    access(0, 0, 1, 32'h0C, 32'h5A5A5A5A, 0, 32'h0, 0, 0);
    access(0, 1, 0, 32'h0C, 32'h0, 0, 32'h5A5A5A5A, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
